// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, bank-state encoding and bit-reversal helper for the FFT front end
package fft_pkg;

  localparam int DATA_W = 12;
  localparam int LOG2_N = 6;
  localparam int N      = 1 << LOG2_N;

  // Life cycle of one ping-pong bank: filled in natural order, drained in bit-reversed order
  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  // Mirror the LOG2_N address bits: bit i of the result is bit LOG2_N-1-i of idx
  function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] idx);
    logic [LOG2_N-1:0] rev;
    for (int i = 0; i < LOG2_N; i++) begin
      rev[i] = idx[LOG2_N-1-i];
    end
    return rev;
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// rtl/fft_frame_bank.sv - one frame of complex samples, synchronous write and asynchronous read
module fft_frame_bank #(
  parameter int WORD_W = 24,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WORD_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WORD_W-1:0] o_rd_data
);

  // Contents need no reset: a bank is only read after a complete frame has been written into it
  logic [WORD_W-1:0] r_mem [1 << ADDR_W];

  // Store one sample per accepted input at its natural position
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fft_input_reorder_6.sv
// rtl/fft_input_reorder_6.sv - ping-pong bit-reversal reorder buffer ahead of the 64-point FFT
module fft_input_reorder_6 #(
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int LOG2_N = fft_pkg::LOG2_N
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_img,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_img,
  output logic [LOG2_N-1:0] out_index,
  output logic              out_last
);

  import fft_pkg::*;

  localparam int                WORD_W   = 2 * DATA_W;
  localparam logic [LOG2_N-1:0] CNT_LAST = '1;

  bank_state_t       r_state0;
  bank_state_t       r_state1;
  bank_state_t       w_state0_nxt;
  bank_state_t       w_state1_nxt;
  bank_state_t       w_wr_state;
  bank_state_t       w_rd_state;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [LOG2_N-1:0] r_wr_cnt;
  logic [LOG2_N-1:0] r_rd_cnt;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_real;
  logic [DATA_W-1:0] r_out_img;
  logic [LOG2_N-1:0] r_out_index;
  logic              r_out_last;

  logic              w_in_ready;
  logic              w_wr_fire;
  logic              w_wr_last;
  logic              w_rd_avail;
  logic              w_load;
  logic              w_rd_last;
  logic [LOG2_N-1:0] w_rd_addr;
  logic [WORD_W-1:0] w_rd_data0;
  logic [WORD_W-1:0] w_rd_data1;
  logic [WORD_W-1:0] w_rd_word;

  assign w_wr_state = r_wr_bank ? r_state1 : r_state0;
  assign w_rd_state = r_rd_bank ? r_state1 : r_state0;

  // The write bank accepts until its frame is complete; a full or draining bank blocks input
  assign w_in_ready = (w_wr_state == BANK_EMPTY) || (w_wr_state == BANK_FILLING);
  assign w_wr_fire  = in_valid && w_in_ready;
  assign w_wr_last  = (r_wr_cnt == CNT_LAST);

  // A bank is readable only once its whole frame is present, so read and write never alias.
  // The output register is refilled when empty or when its current sample is being taken.
  assign w_rd_avail = (w_rd_state == BANK_FULL) || (w_rd_state == BANK_DRAINING);
  assign w_load     = w_rd_avail && (!r_out_valid || out_ready);
  assign w_rd_last  = (r_rd_cnt == CNT_LAST);
  assign w_rd_addr  = bitrev(r_rd_cnt);
  assign w_rd_word  = r_rd_bank ? w_rd_data1 : w_rd_data0;

  fft_frame_bank #(
    .WORD_W (WORD_W),
    .ADDR_W (LOG2_N)
  ) u_bank0 (
    .clk       (clk),
    .i_wr_en   (w_wr_fire && !r_wr_bank),
    .i_wr_addr (r_wr_cnt),
    .i_wr_data ({in_real, in_img}),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data0)
  );

  fft_frame_bank #(
    .WORD_W (WORD_W),
    .ADDR_W (LOG2_N)
  ) u_bank1 (
    .clk       (clk),
    .i_wr_en   (w_wr_fire && r_wr_bank),
    .i_wr_addr (r_wr_cnt),
    .i_wr_data ({in_real, in_img}),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data1)
  );

  // Next bank states: writes move EMPTY/FILLING forward, reads move FULL/DRAINING forward.
  // A bank is released as soon as its last sample moves into the output register, so the
  // upstream can start the next frame without a bubble even while that sample waits.
  always_comb begin
    w_state0_nxt = r_state0;
    w_state1_nxt = r_state1;
    if (w_wr_fire && !r_wr_bank) begin
      w_state0_nxt = w_wr_last ? BANK_FULL : BANK_FILLING;
    end
    if (w_wr_fire && r_wr_bank) begin
      w_state1_nxt = w_wr_last ? BANK_FULL : BANK_FILLING;
    end
    if (w_load && !r_rd_bank) begin
      w_state0_nxt = w_rd_last ? BANK_EMPTY : BANK_DRAINING;
    end
    if (w_load && r_rd_bank) begin
      w_state1_nxt = w_rd_last ? BANK_EMPTY : BANK_DRAINING;
    end
  end

  // Bank state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state0 <= BANK_EMPTY;
      r_state1 <= BANK_EMPTY;
    end else begin
      r_state0 <= w_state0_nxt;
      r_state1 <= w_state1_nxt;
    end
  end

  // Write position and write bank selection; the bank flips on the last sample of a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
    end else if (w_wr_fire) begin
      r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_wr_last) begin
        r_wr_bank <= ~r_wr_bank;
      end
    end
  end

  // Read position and read bank selection; the bank flips after fetching output position N-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_cnt  <= '0;
      r_rd_bank <= 1'b0;
    end else if (w_load) begin
      r_rd_cnt <= r_rd_cnt + 1'b1;
      if (w_rd_last) begin
        r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  // Output register: loads a fresh sample when allowed, otherwise holds while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_real  <= '0;
      r_out_img   <= '0;
      r_out_index <= '0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_real  <= w_rd_word[WORD_W-1:DATA_W];
      r_out_img   <= w_rd_word[DATA_W-1:0];
      r_out_index <= r_rd_cnt;
      r_out_last  <= w_rd_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_real  = r_out_real;
  assign out_img   = r_out_img;
  assign out_index = r_out_index;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_fft_input_reorder_6.sv
// tb/tb_fft_input_reorder_6.sv - randomized scoreboard bench for the bit-reversal reorder buffer
module tb_fft_input_reorder_6;

  localparam int DW = 12;
  localparam int LN = 6;
  localparam int NS = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_real;
  logic [DW-1:0] in_img;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_real;
  logic [DW-1:0] out_img;
  logic [LN-1:0] out_index;
  logic          out_last;

  fft_input_reorder_6 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_real   (in_real),
    .in_img    (in_img),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_img   (out_img),
    .out_index (out_index),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    int            idx;
    bit            last;
  } exp_t;

  logic [2*DW-1:0] in_q[$];
  exp_t            exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_acc, n_out, n_last, n_block;
  int first_acc_edge, last_acc_edge, first_valid_edge, last_out_edge, first_out_idx;
  logic [DW-1:0] got_re[NS];
  logic [DW-1:0] got_im[NS];
  bit            prev_stall;
  logic [DW-1:0] p_re, p_im;
  logic [LN-1:0] p_idx;
  logic          p_last;
  bit            rnd_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reverse the LN-bit index arithmetically: peel low digits, push them in from the right
  function automatic int brev(input int x);
    int r = 0;
    int v = x;
    for (int b = 0; b < LN; b++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  task automatic check(input string name, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic clr();
    n_acc = 0; n_out = 0; n_last = 0; n_block = 0;
    first_acc_edge = -1; last_acc_edge = -1;
    first_valid_edge = -1; last_out_edge = -1; first_out_idx = -1;
  endtask

  // Model and compare: frames gathered in arrival order, released bit-reversed once complete
  always @(negedge clk) begin
    exp_t e;
    exp_t t;
    logic [2*DW-1:0] w;
    if (!rst_n) begin
      in_q.delete();
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {out_valid, out_real, out_img, out_index, out_last},
              {1'b1, p_re, p_im, p_idx, p_last});
      if (out_valid) begin
        if (first_valid_edge < 0) first_valid_edge = cyc;
        if (exp_q.size() == 0) begin
          check("spurious_valid", longint'(out_valid), 0);
        end else if (out_ready) begin
          e = exp_q.pop_front();
          check("sample", {out_real, out_img, out_index, out_last},
                {e.re, e.im, LN'(e.idx), e.last});
          got_re[out_index] = out_real;
          got_im[out_index] = out_img;
          n_out++;
          if (out_last) n_last++;
          if (n_out == 1) first_out_idx = int'(out_index);
          last_out_edge = cyc + 1;
        end
      end
      prev_stall = out_valid && !out_ready;
      p_re = out_real; p_im = out_img; p_idx = out_index; p_last = out_last;
      if (in_valid && !in_ready) n_block++;
      if (in_valid && in_ready) begin
        if (n_acc == 0) first_acc_edge = cyc + 1;
        n_acc++;
        last_acc_edge = cyc + 1;
        in_q.push_back({in_real, in_img});
        if (in_q.size() == NS) begin
          for (int j = 0; j < NS; j++) begin
            w = in_q[brev(j)];
            t.re = w[2*DW-1:DW];
            t.im = w[DW-1:0];
            t.idx = j;
            t.last = (j == NS - 1);
            exp_q.push_back(t);
          end
          in_q.delete();
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im);
    bit acc = 1'b0;
    in_valid = 1'b1; in_real = re; in_img = im;
    for (int t = 0; t < 4000 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int t = 0; t < 4000 && !done; t++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !out_valid;
    end
    check({name, "_drained"}, longint'(done), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit acc;
    rst_n = 1'b0; in_valid = 1'b0; in_real = '0; in_img = '0; out_ready = 1'b0;
    clr();

    // 1: reset state and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_index", longint'(out_index), 0);
    check("rst_out_last", longint'(out_last), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("idle_out_valid", longint'(out_valid), 0);
    check("idle_in_ready", longint'(in_ready), 1);
    @(posedge clk); #1;

    // 2: one ramp frame, pinned values
    clr(); out_ready = 1'b1;
    for (int k = 0; k < NS; k++) send(DW'(k), DW'(-k));
    drain("t2");
    check("t2_re0", longint'(got_re[0]), 0);
    check("t2_re1", longint'(got_re[1]), 32);
    check("t2_re2", longint'(got_re[2]), 16);
    check("t2_re63", longint'(got_re[63]), 63);
    check("t2_im1", longint'(got_im[1]), 4096 - 32);
    check("t2_im2", longint'(got_im[2]), 4096 - 16);
    check("t2_im63", longint'(got_im[63]), 4096 - 63);
    check("t2_n_out", n_out, 64);
    check("t2_n_last", n_last, 1);
    check("t2_latency", first_valid_edge, last_acc_edge + 1);

    // 3: back-pressure fills both banks
    clr(); out_ready = 1'b0; cnt = 0;
    for (int c = 0; c < 200; c++) begin
      in_valid = 1'b1; in_real = DW'(cnt); in_img = ~DW'(cnt);
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) cnt++;
    end
    in_valid = 1'b0;
    check("t3_accepts", cnt, 128);
    @(negedge clk);
    check("t3_in_ready", longint'(in_ready), 0);
    check("t3_out_valid", longint'(out_valid), 1);
    check("t3_held_index", longint'(out_index), 0);
    check("t3_held_real", longint'(out_real), 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("t3");
    check("t3_n_out", n_out, 128);

    // 4: four frames streaming at full rate
    clr(); out_ready = 1'b1;
    for (int i = 0; i < 4 * NS; i++) send(DW'($urandom), DW'($urandom));
    drain("t4");
    check("t4_no_block", n_block, 0);
    check("t4_n_out", n_out, 256);
    check("t4_n_last", n_last, 4);
    check("t4_first_valid", first_valid_edge, first_acc_edge + 64);
    check("t4_continuous", last_out_edge - first_valid_edge, 256);

    // 5: reset mid-frame drops the partial frame
    clr(); out_ready = 1'b1;
    for (int i = 0; i < 30; i++) send(DW'($urandom), DW'($urandom));
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr();
    repeat (80) @(posedge clk);
    #1;
    check("t5_no_output", first_valid_edge, -1);
    for (int i = 0; i < NS; i++) send(DW'($urandom), DW'($urandom));
    drain("t5");
    check("t5_n_out", n_out, 64);
    check("t5_first_index", first_out_idx, 0);

    // 6: random handshakes on both sides over 20 frames
    clr(); rnd_on = 1'b1;
    fork
      forever begin
        out_ready = rnd_on ? 1'($urandom % 2) : 1'b1;
        @(posedge clk); #1;
      end
    join_none
    for (int i = 0; i < 20 * NS; i++) begin
      if ($urandom % 2 == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      send(DW'($urandom), DW'($urandom));
    end
    rnd_on = 1'b0;
    drain("t6");
    check("t6_n_acc", n_acc, 20 * NS);
    check("t6_n_out", n_out, 20 * NS);
    check("t6_n_last", n_last, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
